lane_move_ctrl: RTL and testbench

Sits between the raw direction sources (the keyboard arrow decoder and the synchronized KEY buttons) and the player object that draws to the VGA adapter. Debounces the level-sensitive left/right requests and turns each press into exactly one single-cycle move pulse, with optional typematic auto-repeat. Owns the authoritative lane register, saturating at 0 and NUM_LANES-1. Also accepts a synchronous re-centre request.

---
 rtl/lane_runner_pkg.sv | 25 ++
 rtl/key_debounce.sv | 63 ++++++
 rtl/lane_move_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_lane_move_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_runner_pkg.sv
// lane_runner_pkg: shared lane-runner constants and the direction FSM state type.
// Configuration macro: LANE_AUTO_REPEAT_EN (defined: three-state typematic FSM;
// undefined: two-state press FSM, no repeat timer).
package lane_runner_pkg;

   localparam int unsigned LANE_W             = 3;
   localparam int unsigned NUM_LANES_DEFAULT  = 5;
   localparam int unsigned START_LANE_DEFAULT = 2;

`ifdef LANE_AUTO_REPEAT_EN
   localparam int unsigned TIMER_W = 25;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      HELD_DELAY  = 2'd1,
      HELD_REPEAT = 2'd2
   } move_state_e;
`else
   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } move_state_e;
`endif

endpackage

// File: rtl/key_debounce.sv
// key_debounce: debounces one level-sensitive, already-synchronized request.
// The debounced level only changes after DEBOUNCE_CYC consecutive cycles of a
// disagreeing sample; rise_o/fall_o are one-cycle strobes registered together
// with the level change. Used by lane_move_ctrl (macro LANE_AUTO_REPEAT_EN does
// not affect this block).
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic rise_o,
   output logic fall_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sample_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flip;
   logic             rise_q, fall_q;

   // Count consecutive disagreeing samples; the step that would reach
   // DEBOUNCE_CYC flips the level and clears the counter instead.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      cnt_d = '0;
      flip  = 1'b0;
      if (sample_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            flip = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Sample register, stability counter, debounced level and edge strobes.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking (<=) so every register sees pre-edge values.
      if (reset) begin
         sample_q <= 1'b0;
         level_q  <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sample_q <= raw_i;
         cnt_q    <= cnt_d;
         rise_q   <= flip & ~level_q;
         fall_q   <= flip & level_q;
         if (flip) begin
            level_q <= ~level_q;
         end
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/lane_move_ctrl.sv
// lane_move_ctrl: turns debounced left/right requests into single-cycle move
// events (with optional typematic repeat) and owns the saturating lane register.
// Configuration macro: LANE_AUTO_REPEAT_EN
//   defined   - per-direction FSM IDLE -> HELD_DELAY -> HELD_REPEAT with a
//               25-bit repeat timer (REPEAT_DELAY_CYC, then REPEAT_RATE_CYC).
//   undefined - per-direction FSM IDLE <-> HELD, one event per press, no timer.
module lane_move_ctrl
   import lane_runner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC     = 500000,
   parameter int unsigned REPEAT_DELAY_CYC = 25000000,
   parameter int unsigned REPEAT_RATE_CYC  = 7500000,
   parameter int unsigned NUM_LANES        = NUM_LANES_DEFAULT,
   parameter int unsigned START_LANE       = START_LANE_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              left_in,
   input  logic              right_in,
   input  logic              center_req,
   output logic              move_left,
   output logic              move_right,
   output logic [LANE_W-1:0] lane,
   output logic              lane_changed,
   output logic              blocked
);

   localparam int unsigned DIR_L = 0;
   localparam int unsigned DIR_R = 1;

   localparam logic [LANE_W-1:0] START_V = LANE_W'(START_LANE);
   localparam logic [LANE_W-1:0] LAST_V  = LANE_W'(NUM_LANES - 1);

   logic [1:0] dir_raw;
   logic [1:0] dir_event;

   assign dir_raw = {right_in, left_in};

   // One debouncer and one press FSM per direction; each FSM produces a
   // registered one-cycle move event.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dir
      logic        rise, fall;
      logic        event_q, event_d;
      move_state_e state_q, state_d;

      key_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw_i (dir_raw[gi]),
         .rise_o(rise),
         .fall_o(fall)
      );

`ifdef LANE_AUTO_REPEAT_EN
      localparam logic [TIMER_W-1:0] DELAY_LOAD = TIMER_W'(REPEAT_DELAY_CYC);
      localparam logic [TIMER_W-1:0] RATE_LOAD  = TIMER_W'(REPEAT_RATE_CYC);

      logic [TIMER_W-1:0] timer_q, timer_d;

      // Next state: a release always wins; while held, the timer counts down
      // to 1 and expiry issues an event and reloads the repeat period.
      always_comb begin
         state_d = state_q;
         timer_d = timer_q;
         event_d = 1'b0;
         if (fall) begin
            state_d = IDLE;
            timer_d = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rise) begin
                     state_d = HELD_DELAY;
                     timer_d = DELAY_LOAD;
                     event_d = 1'b1;
                  end
               end
               HELD_DELAY, HELD_REPEAT: begin
                  if (timer_q == TIMER_W'(1)) begin
                     state_d = HELD_REPEAT;
                     timer_d = RATE_LOAD;
                     event_d = 1'b1;
                  end else begin
                     timer_d = timer_q - 1'b1;
                  end
               end
               default: begin
                  state_d = IDLE;
                  timer_d = '0;
               end
            endcase
         end
      end

      // State, timer and event registers.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            event_q <= 1'b0;
         end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            event_q <= event_d;
         end
      end
`else
      // Next state: one event on the debounced rise, back to IDLE on the fall.
      always_comb begin
         state_d = state_q;
         event_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_d = HELD;
                  event_d = 1'b1;
               end
            end
            HELD: begin
               if (fall) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // State and event registers.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= IDLE;
            event_q <= 1'b0;
         end else begin
            state_q <= state_d;
            event_q <= event_d;
         end
      end
`endif

      assign dir_event[gi] = event_q;
   end

`ifndef LANE_AUTO_REPEAT_EN
   // The repeat parameters stay on the interface so one instantiation serves
   // both builds; this empty block is their only reference without repeat.
   if (REPEAT_DELAY_CYC == 0 || REPEAT_RATE_CYC == 0) begin : g_repeat_cfg_zero
   end
`endif

   logic              ev_left, ev_right;
   logic [LANE_W-1:0] lane_q;
   logic              move_left_q, move_right_q, lane_changed_q, blocked_q;

   assign ev_left  = dir_event[DIR_L];
   assign ev_right = dir_event[DIR_R];

   // Lane register and output pulses: centre beats moves, simultaneous
   // left+right events cancel, and moves saturate at the edge lanes.
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q         <= START_V;
         move_left_q    <= 1'b0;
         move_right_q   <= 1'b0;
         lane_changed_q <= 1'b0;
         blocked_q      <= 1'b0;
      end else begin
         move_left_q    <= 1'b0;
         move_right_q   <= 1'b0;
         lane_changed_q <= 1'b0;
         blocked_q      <= 1'b0;
         if (center_req) begin
            lane_q         <= START_V;
            lane_changed_q <= (lane_q != START_V);
         end else if (ev_left && !ev_right) begin
            if (lane_q != '0) begin
               lane_q         <= lane_q - 1'b1;
               move_left_q    <= 1'b1;
               lane_changed_q <= 1'b1;
            end else begin
               blocked_q <= 1'b1;
            end
         end else if (ev_right && !ev_left) begin
            if (lane_q < LAST_V) begin
               lane_q         <= lane_q + 1'b1;
               move_right_q   <= 1'b1;
               lane_changed_q <= 1'b1;
            end else begin
               blocked_q <= 1'b1;
            end
         end
      end
   end

   assign lane         = lane_q;
   assign move_left    = move_left_q;
   assign move_right   = move_right_q;
   assign lane_changed = lane_changed_q;
   assign blocked      = blocked_q;

endmodule

// File: tb/tb_lane_move_ctrl.sv
// tb_lane_move_ctrl: bench for lane_move_ctrl with DEBOUNCE_CYC=4,
// REPEAT_DELAY_CYC=20, REPEAT_RATE_CYC=8. Expectations follow the build:
// LANE_AUTO_REPEAT_EN defined selects the typematic schedule.
module tb_lane_move_ctrl;

   localparam int unsigned DEB       = 4;
   localparam int unsigned DLY       = 20;
   localparam int unsigned RATE      = 8;
   localparam int unsigned LANES     = 5;
   localparam int unsigned START     = 2;
   localparam int unsigned IDLE_GAP  = 3 * DEB + 6;
   localparam int unsigned NROWS     = 11;

   // Pulse bits: {move_left, move_right, lane_changed, blocked}
   localparam logic [3:0] P_LEFT   = 4'b1010;
   localparam logic [3:0] P_RIGHT  = 4'b0110;
   localparam logic [3:0] P_CENTER = 4'b0010;
   localparam logic [3:0] P_BLOCK  = 4'b0001;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  pulses;
      logic [2:0]  lane;
   } exp_ev_t;

   typedef struct {
      bit          l;
      bit          r;
      int unsigned hold;
      int unsigned n_rep;
      int unsigned lane_rep;
      int unsigned n_one;
      int unsigned lane_one;
   } row_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       left_in, right_in, center_req;
   logic       move_left, move_right, lane_changed, blocked;
   logic [2:0] lane;

   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned n_pulse_obs = 0;
   int          exp_lane;
   exp_ev_t     sb_q[$];
   exp_ev_t     mon_e;
   logic [3:0]  mon_obs;
   row_t        rows[NROWS];

   lane_move_ctrl #(
      .DEBOUNCE_CYC    (DEB),
      .REPEAT_DELAY_CYC(DLY),
      .REPEAT_RATE_CYC (RATE),
      .NUM_LANES       (LANES),
      .START_LANE      (START)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .left_in     (left_in),
      .right_in    (right_in),
      .center_req  (center_req),
      .move_left   (move_left),
      .move_right  (move_right),
      .lane        (lane),
      .lane_changed(lane_changed),
      .blocked     (blocked)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected pulses for a press whose first sampling edge is c0 and which is
   // held for 'hold' sampled cycles: first pulse at c0+DEB+2, then repeats at
   // +DLY, +RATE... while the release has not yet reached the FSM.
   task automatic push_press(input int unsigned c0, input bit l, input bit r,
                             input int unsigned hold);
      int unsigned off;
      exp_ev_t     e;
      if (l && r) return;
      if (hold < DEB) return;
      off = 0;
      while (off <= hold - 1) begin
         e.cyc = c0 + DEB + 2 + off;
         if (l) begin
            if (exp_lane > 0) begin
               exp_lane--;
               e.pulses = P_LEFT;
            end else begin
               e.pulses = P_BLOCK;
            end
         end else begin
            if (exp_lane < int'(LANES) - 1) begin
               exp_lane++;
               e.pulses = P_RIGHT;
            end else begin
               e.pulses = P_BLOCK;
            end
         end
         e.lane = 3'(exp_lane);
         sb_q.push_back(e);
`ifdef LANE_AUTO_REPEAT_EN
         off += (off == 0) ? DLY : RATE;
`else
         break;
`endif
      end
   endtask

   // Monitor: every observed pulse is matched against the scoreboard head.
   always @(negedge clk) begin
      mon_obs = {move_left, move_right, lane_changed, blocked};
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
         mon_e = sb_q.pop_front();
         check("pulse_cycle_missed", cyc, mon_e.cyc);
      end
      if (mon_obs != 4'b0) begin
         n_pulse_obs++;
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'(mon_obs), 32'(4'b0));
         end else begin
            mon_e = sb_q.pop_front();
            check("pulse_cycle", cyc, mon_e.cyc);
            check("pulse_kind", 32'(mon_obs), 32'(mon_e.pulses));
            check("pulse_lane", 32'(lane), 32'(mon_e.lane));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned n_start;
      int unsigned c0;
      int unsigned exp_n, exp_l;

      //            l  r  hold rep:n lane  one:n lane
      rows[0]  = '{1, 0, 10,  1,  1,  1, 1};
      rows[1]  = '{0, 1, 3,   0,  1,  0, 1};
      rows[2]  = '{0, 1, 4,   1,  2,  1, 2};
      rows[3]  = '{0, 1, 60,  6,  4,  1, 3};
      rows[4]  = '{0, 1, 10,  1,  4,  1, 4};
      rows[5]  = '{1, 1, 10,  0,  4,  0, 4};
      rows[6]  = '{1, 0, 100, 11, 0,  1, 3};
      rows[7]  = '{1, 0, 10,  1,  0,  1, 2};
      rows[8]  = '{1, 0, 10,  1,  0,  1, 1};
      rows[9]  = '{1, 0, 10,  1,  0,  1, 0};
      rows[10] = '{1, 0, 10,  1,  0,  1, 0};

      reset      = 1'b1;
      left_in    = 1'b0;
      right_in   = 1'b0;
      center_req = 1'b0;
      exp_lane   = int'(START);
      repeat (3) @(negedge clk);
      check("reset_lane", 32'(lane), START);
      check("reset_pulses", 32'({move_left, move_right, lane_changed, blocked}), 0);
      reset = 1'b0;

      // Idle after reset: no pulses, lane holds.
      n_start = n_pulse_obs;
      repeat (50) @(negedge clk);
      check("idle_lane", 32'(lane), START);
      check("idle_pulses", n_pulse_obs - n_start, 0);

      // Bounce: right toggles every 2 cycles, never stable long enough.
      n_start = n_pulse_obs;
      for (int k = 0; k < 10; k++) begin
         right_in = (k % 2 == 0);
         repeat (2) @(negedge clk);
      end
      right_in = 1'b0;
      repeat (IDLE_GAP) @(negedge clk);
      check("bounce_pulses", n_pulse_obs - n_start, 0);
      check("bounce_lane", 32'(lane), START);

      // Table-driven presses.
      for (int i = 0; i < NROWS; i++) begin
`ifdef LANE_AUTO_REPEAT_EN
         exp_n = rows[i].n_rep;
         exp_l = rows[i].lane_rep;
`else
         exp_n = rows[i].n_one;
         exp_l = rows[i].lane_one;
`endif
         n_start = n_pulse_obs;
         @(negedge clk);
         left_in  = rows[i].l;
         right_in = rows[i].r;
         push_press(cyc + 1, rows[i].l, rows[i].r, rows[i].hold);
         repeat (rows[i].hold) @(negedge clk);
         left_in  = 1'b0;
         right_in = 1'b0;
         repeat (IDLE_GAP) @(negedge clk);
         check($sformatf("row%0d_pulses", i), n_pulse_obs - n_start, exp_n);
         check($sformatf("row%0d_lane", i), 32'(lane), exp_l);
         check($sformatf("row%0d_sb_empty", i), 32'(sb_q.size()), 0);
      end

      // Centre from lane 0: lane_changed once, lane back to START.
      @(negedge clk);
      center_req = 1'b1;
      sb_q.push_back('{cyc + 1, P_CENTER, 3'(START)});
      exp_lane = int'(START);
      @(negedge clk);
      center_req = 1'b0;
      repeat (5) @(negedge clk);
      check("center_lane", 32'(lane), START);

      // Centre while already at START: no pulse at all.
      n_start = n_pulse_obs;
      center_req = 1'b1;
      @(negedge clk);
      center_req = 1'b0;
      repeat (5) @(negedge clk);
      check("center_noop_pulses", n_pulse_obs - n_start, 0);

      // Left tap to lane 1, then a right press whose event collides with centre.
      @(negedge clk);
      left_in = 1'b1;
      push_press(cyc + 1, 1'b1, 1'b0, 10);
      repeat (10) @(negedge clk);
      left_in = 1'b0;
      repeat (IDLE_GAP) @(negedge clk);
      check("pre_center_lane", 32'(lane), 1);
      right_in = 1'b1;
      c0 = cyc + 1;
      sb_q.push_back('{c0 + DEB + 2, P_CENTER, 3'(START)});
      exp_lane = int'(START);
      repeat (DEB + 2) @(negedge clk);
      center_req = 1'b1;
      @(negedge clk);
      center_req = 1'b0;
      repeat (3) @(negedge clk);
      right_in = 1'b0;
      repeat (IDLE_GAP) @(negedge clk);
      check("center_beats_move_lane", 32'(lane), START);

      // Reset mid-hold: lane returns to START, held input counts as a new press.
      @(negedge clk);
      right_in = 1'b1;
      push_press(cyc + 1, 1'b0, 1'b1, 10);
      repeat (10) @(negedge clk);
      check("hold_before_reset_lane", 32'(lane), START + 1);
      reset = 1'b1;
      exp_lane = int'(START);
      @(negedge clk);
      reset = 1'b0;
      check("midhold_reset_lane", 32'(lane), START);
      check("midhold_reset_pulses", 32'({move_left, move_right, lane_changed, blocked}), 0);
      push_press(cyc + 1, 1'b0, 1'b1, 10);
      repeat (10) @(negedge clk);
      right_in = 1'b0;
      repeat (IDLE_GAP) @(negedge clk);
      check("after_reset_press_lane", 32'(lane), START + 1);
      check("final_sb_empty", 32'(sb_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
